// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 write engine:
//   - FSM state encoding
//   - HD44780 command bytes used by the power-on initialisation
//   - initialisation sequence length and index width
//   - bit positions inside the {RS, RW} control field
//   - helpers for execution-wait selection and counter sizing
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERON = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNCTION_SET_8BIT = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON        = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE        = 8'h06;
  localparam logic [7:0] CMD_CLEAR             = 8'h01;

  localparam int INIT_LEN   = 4;
  localparam int INIT_IDX_W = 2;

  // lcd_ctrl = {RS, RW}
  localparam int CTRL_RS_BIT = 1;
  localparam int CTRL_RW_BIT = 0;

  // Clear (0x01) and return-home (0x02/0x03) are the slow instructions;
  // everything else, including any data byte, uses the normal wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// ---------------------------------------------------------------------------
// lcd_init_rom
// Combinational lookup of the power-on initialisation byte sequence.
// Ports:
//   idx  in  2 : position in the init sequence (0..INIT_LEN-1)
//   data out 8 : command byte to issue at that position (RS=0)
// ---------------------------------------------------------------------------
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx,
  output logic [7:0]            data
);

  always_comb begin
    data = CMD_CLEAR;
    case (idx)
      2'd0:    data = CMD_FUNCTION_SET_8BIT;
      2'd1:    data = CMD_DISPLAY_ON;
      2'd2:    data = CMD_ENTRY_MODE;
      default: data = CMD_CLEAR;
    endcase
  end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_driver
// Timed write engine for an HD44780-compatible character LCD. Accepts one
// command/data byte per valid/ready handshake and generates the setup,
// enable pulse, hold and execution-wait intervals on the LCD bus. Optionally
// runs the power-on initialisation sequence by itself after reset.
// Ports:
//   clk        in   1 : clock, rising edge
//   rst        in   1 : asynchronous active-high reset
//   req_valid  in   1 : request present
//   req_ready  out  1 : request can be accepted this cycle
//   req_rs     in   1 : 0 = command, 1 = character data
//   req_data   in   8 : byte to write
//   busy       out  1 : engine not idle
//   init_done  out  1 : sticky, initialisation finished
//   lcd_data   out  8 : LCD D7..D0
//   lcd_ctrl   out  2 : {RS, RW}, RW always 0
//   lcd_enable out  1 : LCD E strobe (registered)
// ---------------------------------------------------------------------------
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 1000,
  parameter int CLEAR_WAIT_CYCLES = 41000,
  parameter int POWERON_CYCLES    = 375000,
  parameter int INIT_ENABLE       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic [1:0] lcd_ctrl,
  output logic       lcd_enable
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYCLES, PULSE_CYCLES),
                                           max_int(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                   max_int(CLEAR_WAIT_CYCLES, POWERON_CYCLES));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lcd_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
  logic                  init_done_q, init_done_d;
  logic                  long_wait_q, long_wait_d;
  logic [7:0]            data_q, data_d;
  logic                  rs_q, rs_d;
  logic                  enable_q, enable_d;

  logic [INIT_IDX_W-1:0] rom_idx;
  logic [7:0]            rom_data;
  logic                  launch_init;
  logic                  cnt_last;

  // Look ahead to the next init byte while leaving WAIT so the ROM output
  // is ready to be latched on the same edge that re-enters SETUP.
  assign rom_idx = (state_q == ST_WAIT) ? (idx_q + 2'd1) : idx_q;

  lcd_init_rom u_init_rom (
    .idx  (rom_idx),
    .data (rom_data)
  );

  assign cnt_last = (cnt_q == CNT_ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    long_wait_d = long_wait_q;
    data_d      = data_q;
    rs_d        = rs_q;
    launch_init = 1'b0;

    case (state_q)
      ST_POWERON: begin
        // The counter leaves reset at 0, so the first POWERON cycle loads
        // the remaining count; that cycle itself counts as the first one.
        if (cnt_q == '0) begin
          if (POWERON_CYCLES == 1) begin
            launch_init = 1'b1;
          end else begin
            cnt_d = CNT_W'(POWERON_CYCLES - 1);
          end
        end else if (cnt_last) begin
          launch_init = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_IDLE: begin
        if (INIT_ENABLE == 0) begin
          init_done_d = 1'b1;
        end
        if (req_valid && init_done_q) begin
          data_d      = req_data;
          rs_d        = req_rs;
          long_wait_d = is_long_cmd(req_rs, req_data);
          state_d     = ST_SETUP;
          cnt_d       = CNT_W'(SETUP_CYCLES);
        end
      end

      ST_SETUP: begin
        if (cnt_last) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_PULSE: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait_q ? CNT_W'(CLEAR_WAIT_CYCLES) : CNT_W'(CMD_WAIT_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d       = idx_q + 2'd1;
            launch_init = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (launch_init) begin
      data_d      = rom_data;
      rs_d        = 1'b0;
      long_wait_d = is_long_cmd(1'b0, rom_data);
      state_d     = ST_SETUP;
      cnt_d       = CNT_W'(SETUP_CYCLES);
    end
  end

  // E is registered from the next state so it is a clean flop output that
  // is high exactly for the PULSE cycles.
  assign enable_d = (state_d == ST_PULSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (INIT_ENABLE != 0) ? ST_POWERON : ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      long_wait_q <= 1'b0;
      data_q      <= 8'd0;
      rs_q        <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      long_wait_q <= long_wait_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      enable_q    <= enable_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && init_done_q;
  // Reset parks the FSM in POWERON; keep busy low until reset is released.
  assign busy       = (state_q != ST_IDLE) && !rst;
  assign init_done  = init_done_q;
  assign lcd_data   = data_q;
  assign lcd_enable = enable_q;

  always_comb begin
    lcd_ctrl              = 2'b00;
    lcd_ctrl[CTRL_RS_BIT] = rs_q;
    lcd_ctrl[CTRL_RW_BIT] = 1'b0;
  end

endmodule
